// File: rtl/speed_buttons.sv
// speed_buttons: synchronizes, debounces and auto-repeats two raw push-buttons into
// mutually exclusive one-cycle up/down pulses plus debounced held levels.
module speed_buttons #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_DELAY = 200,
   parameter int REPEAT_RATE = 50,
   parameter bit REPEAT_EN = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_up_raw,
   input  logic btn_down_raw,
   output logic up,
   output logic down,
   output logic up_held,
   output logic down_held
);
   localparam logic [2:0] IDLE = 3'd0, PRESS_DEB = 3'd1, HELD_WAIT = 3'd2, REPEAT = 3'd3, RELEASE_DEB = 3'd4;
   localparam logic [7:0] DEB = 8'(DEBOUNCE_CYCLES);
   localparam logic [15:0] DLY = 16'(REPEAT_DELAY);
   localparam logic [15:0] RATE = 16'(REPEAT_RATE);

   logic [1:0] s1, s2, held, req, hn;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= {btn_down_raw, btn_up_raw};
         s2 <= s1;
      end

   // bit 0 is the up button, bit 1 the down button
   for (genvar b = 0; b < 2; b++) begin : g_btn
      logic [2:0] st, st_n, ret, ret_n, ph, ph_n;
      logic [7:0] cnt, cnt_n, cinc;
      logic [15:0] tmr, tmr_n, tinc, tnew;
      logic hit, req_b, hn_b, in;
      assign in = s2[b];
      assign req[b] = req_b;
      assign hn[b] = hn_b;
      always_comb begin
         ph = (st == RELEASE_DEB) ? ret : st;
         tinc = tmr + 16'd1;
         hit = (ph == REPEAT || REPEAT_EN) && tinc == ((ph == REPEAT) ? RATE : DLY);
         ph_n = hit ? REPEAT : ph;
         tnew = hit ? 16'd0 : (&tmr ? tmr : tinc);
         cinc = cnt + 8'd1;
         st_n = st;
         ret_n = ret;
         cnt_n = cnt;
         tmr_n = tmr;
         req_b = 1'b0;
         hn_b = held[b];
         case (st)
            IDLE: begin
               st_n = in ? PRESS_DEB : IDLE;
               cnt_n = in ? 8'd1 : 8'd0;
            end
            PRESS_DEB:
               if (!in) begin
                  st_n = IDLE;
                  cnt_n = '0;
               end else if (cinc == DEB) begin
                  st_n = HELD_WAIT;
                  hn_b = 1'b1;
                  req_b = 1'b1;
                  tmr_n = '0;
                  cnt_n = '0;
               end else cnt_n = cinc;
            HELD_WAIT, REPEAT: begin
               tmr_n = tnew;
               req_b = hit;
               ret_n = ph_n;
               st_n = in ? ph_n : RELEASE_DEB;
               cnt_n = in ? 8'd0 : 8'd1;
            end
            RELEASE_DEB: begin
               // timer keeps its schedule; any pulse falling in here is swallowed
               tmr_n = tnew;
               ret_n = ph_n;
               if (in) begin
                  st_n = ph_n;
                  cnt_n = '0;
               end else if (cinc == DEB) begin
                  st_n = IDLE;
                  hn_b = 1'b0;
                  cnt_n = '0;
                  tmr_n = '0;
               end else cnt_n = cinc;
            end
            default: st_n = IDLE;
         endcase
      end
      always_ff @(posedge clk or posedge rst)
         if (rst) begin
            st <= IDLE;
            ret <= IDLE;
            cnt <= '0;
            tmr <= '0;
         end else begin
            st <= st_n;
            ret <= ret_n;
            cnt <= cnt_n;
            tmr <= tmr_n;
         end
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         up <= 1'b0;
         down <= 1'b0;
         held <= '0;
      end else begin
         up <= req[0] & ~req[1] & ~(&hn);
         down <= req[1] & ~req[0] & ~(&hn);
         held <= hn;
      end

   assign up_held = held[0];
   assign down_held = held[1];
endmodule

// File: tb/tb_speed_buttons.sv
// tb_speed_buttons: directed scenarios plus random presses/bounces, checked every cycle
// against a run-length/deadline model of the button conditioner.
module tb_speed_buttons;
   localparam int D = 4, RD = 20, RR = 8;
   localparam bit EN = 1'b1;

   logic clk = 1'b0, rst, bu, bd;
   logic up, down, up_held, down_held;
   int tests = 0, fails = 0, ecnt = 0, e0, e1, ph_u = 0;
   int upq[$], dnq[$], hrq[$], hfq[$];

   // model state: sync pipe, held flag, consecutive opposite samples, time since
   // last repeat deadline, number of deadlines passed in this hold
   bit ms1[2], ms2[2], mheld[2], m_up, m_dn;
   int deb[2], t[2], nrep[2];

   speed_buttons #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .REPEAT_EN(EN)) dut (
      .clk(clk), .rst(rst), .btn_up_raw(bu), .btn_down_raw(bd),
      .up(up), .down(down), .up_held(up_held), .down_held(down_held)
   );

   always #5 clk = ~clk;
   always @(posedge clk) ecnt++;

   function automatic void mreset();
      for (int i = 0; i < 2; i++) begin
         ms1[i] = 0; ms2[i] = 0; mheld[i] = 0; deb[i] = 0; t[i] = 0; nrep[i] = 0;
      end
      m_up = 0; m_dn = 0;
   endfunction

   function automatic void mstep();
      bit rq[2];
      bit both;
      for (int i = 0; i < 2; i++) begin
         bit sv = ms2[i];
         rq[i] = 0;
         if (!mheld[i]) begin
            if (sv) begin
               deb[i]++;
               if (deb[i] == D) begin mheld[i] = 1; deb[i] = 0; t[i] = 0; nrep[i] = 0; rq[i] = 1; end
            end else deb[i] = 0;
         end else begin
            bit fire = 0;
            int prev = deb[i];
            t[i]++;
            if ((nrep[i] > 0 || EN) && t[i] == (nrep[i] == 0 ? RD : RR)) begin t[i] = 0; nrep[i]++; fire = 1; end
            if (sv) deb[i] = 0;
            else begin
               deb[i]++;
               if (deb[i] == D) begin mheld[i] = 0; deb[i] = 0; end
            end
            rq[i] = fire && prev == 0;
         end
      end
      both = mheld[0] && mheld[1];
      m_up = rq[0] && !rq[1] && !both;
      m_dn = rq[1] && !rq[0] && !both;
      ms2[0] = ms1[0]; ms2[1] = ms1[1];
      ms1[0] = bu; ms1[1] = bd;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) mreset(); else mstep();
      #1;
      tests += 5;
      if (up !== m_up) begin fails++; $display("FAIL up @%0d: got %b want %b", ecnt, up, m_up); end
      if (down !== m_dn) begin fails++; $display("FAIL down @%0d: got %b want %b", ecnt, down, m_dn); end
      if (up_held !== mheld[0]) begin fails++; $display("FAIL up_held @%0d: got %b want %b", ecnt, up_held, mheld[0]); end
      if (down_held !== mheld[1]) begin fails++; $display("FAIL down_held @%0d: got %b want %b", ecnt, down_held, mheld[1]); end
      if (up === 1'b1 && down === 1'b1) begin fails++; $display("FAIL exclusive @%0d: up=1 down=1 want not both", ecnt); end
      if (up === 1'b1) upq.push_back(ecnt);
      if (down === 1'b1) dnq.push_back(ecnt);
      if (up_held === 1'b1 && ph_u == 0) hrq.push_back(ecnt);
      if (up_held === 1'b0 && ph_u == 1) hfq.push_back(ecnt);
      ph_u = (up_held === 1'b1) ? 1 : 0;
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin fails++; $display("FAIL %s: got %0d want %0d", name, act, exp); end
   endtask

   function automatic int first_off(input int q[$], input int base);
      return (q.size() > 0) ? q[0] - base : -1;
   endfunction

   task automatic mark();
      upq.delete(); dnq.delete(); hrq.delete(); hfq.delete();
      e0 = ecnt;
   endtask

   initial begin
      int exp5[7] = '{6, 26, 34, 42, 50, 58, 66};
      int exp3[6] = '{0, 20, 28, 36, 44, 52};
      bit pat[9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
      int ru = 0, rd = 0;
      rst = 1; bu = 0; bd = 0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {up, down, up_held, down_held}, 0);
      rst = 0;
      repeat (2) @(negedge clk);

      // clean press, short hold
      mark(); bu = 1;
      repeat (12) @(negedge clk);
      e1 = ecnt; bu = 0;
      repeat (12) @(negedge clk);
      chk("clean_npulse", upq.size(), 1);
      chk("clean_edge", first_off(upq, e0), 6);
      chk("clean_held_rise", first_off(hrq, e0), 6);
      chk("clean_held_fall", first_off(hfq, e1), 6);
      chk("clean_down", dnq.size(), 0);

      // bouncing press
      mark();
      for (int c = 0; c < 9; c++) begin bu = pat[c]; @(negedge clk); end
      repeat (10) @(negedge clk);
      bu = 0;
      repeat (12) @(negedge clk);
      chk("bounce_npulse", upq.size(), 1);
      chk("bounce_edge", first_off(upq, e0), 11);

      // down held with auto-repeat
      mark(); bd = 1;
      repeat (61) @(negedge clk);
      bd = 0;
      repeat (30) @(negedge clk);
      chk("repeat_npulse", dnq.size(), 6);
      if (dnq.size() == 6) for (int i = 0; i < 6; i++) chk("repeat_edge", dnq[i] - dnq[0], exp3[i]);
      chk("repeat_first", first_off(dnq, e0), 6);
      chk("repeat_up", upq.size(), 0);

      // both pressed together, then down released
      mark(); bu = 1; bd = 1;
      repeat (40) @(negedge clk);
      chk("both_pulses", upq.size() + dnq.size(), 0);
      chk("both_held", {up_held, down_held}, 3);
      bd = 0;
      repeat (40) @(negedge clk);
      bu = 0;
      repeat (15) @(negedge clk);
      chk("resume_npulse", upq.size(), 5);
      chk("resume_first", first_off(upq, e0), 50);
      chk("resume_down", dnq.size(), 0);

      // 2-cycle glitch mid-repeat, then a real release
      mark();
      for (int c = 0; c < 64; c++) begin bu = !(c == 35 || c == 36); @(negedge clk); end
      bu = 0;
      repeat (30) @(negedge clk);
      chk("glitch_npulse", upq.size(), 7);
      if (upq.size() == 7) for (int i = 0; i < 7; i++) chk("glitch_edge", upq[i] - e0, exp5[i]);
      chk("glitch_nfall", hfq.size(), 1);
      chk("glitch_fall", first_off(hfq, e0), 70);

      // reset mid-hold
      bu = 1;
      repeat (30) @(negedge clk);
      chk("pre_rst_held", up_held, 1);
      rst = 1;
      #1;
      chk("rst_async", {up, down, up_held, down_held}, 0);
      @(negedge clk);
      rst = 0;
      mark();
      repeat (10) @(negedge clk);
      chk("rst_repress", first_off(upq, e0), 6);
      bu = 0;
      repeat (12) @(negedge clk);

      // random presses, bounces and occasional resets
      for (int c = 0; c < 5000; c++) begin
         if (ru == 0) begin bu = !bu; ru = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : $urandom_range(5, 90); end
         if (rd == 0) begin bd = !bd; rd = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : $urandom_range(5, 90); end
         ru--; rd--;
         rst = ($urandom_range(0, 799) == 0);
         @(negedge clk);
      end
      rst = 0; bu = 0; bd = 0;
      repeat (20) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
